// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB PWM output path.
package rgb_pkg;

  localparam int DEFAULT_PWM_BITS = 8;

  localparam logic [DEFAULT_PWM_BITS-1:0] DUTY_MAX = '1;

  typedef struct packed {
    logic [DEFAULT_PWM_BITS-1:0] red;
    logic [DEFAULT_PWM_BITS-1:0] green;
    logic [DEFAULT_PWM_BITS-1:0] blue;
  } color_t;

  localparam color_t COLOR_OFF   = '{red: '0,       green: '0,       blue: '0};
  localparam color_t COLOR_RED   = '{red: DUTY_MAX, green: '0,       blue: '0};
  localparam color_t COLOR_GREEN = '{red: '0,       green: DUTY_MAX, blue: '0};
  localparam color_t COLOR_BLUE  = '{red: '0,       green: '0,       blue: DUTY_MAX};
  localparam color_t COLOR_WHITE = '{red: DUTY_MAX, green: DUTY_MAX, blue: DUTY_MAX};

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM pin: registered compare of the shared phase against this channel's duty.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] i_phase,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_enable,
  output logic                o_pin
);

  logic r_pin;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pin <= 1'b0;
    else        r_pin <= i_enable && (i_phase < i_duty);
  end

  assign o_pin = r_pin;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: one-deep command slot, duties swapped only at PWM period boundaries.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = DEFAULT_PWM_BITS,
  parameter int PRESCALE = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3*PWM_BITS-1:0] cmd_color,
  input  logic                  enable,
  output logic [2:0]            rgb,
  output logic                  period_start
);

  localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]       r_presc;
  logic [PWM_BITS-1:0]   r_phase;
  logic [3*PWM_BITS-1:0] r_duty;
  logic [3*PWM_BITS-1:0] r_pend_color;
  logic                  r_pend_valid;
  logic                  r_period_start;

  logic w_tick;
  logic w_boundary;
  logic w_accept;

  assign w_tick     = (r_presc == PS_LAST);
  assign w_boundary = w_tick && (r_phase == '1);
  assign cmd_ready  = !r_pend_valid;
  assign w_accept   = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_phase <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_phase <= r_phase + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Swap and accept are exclusive: accept needs an empty slot, swap needs a full one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty         <= '0;
      r_pend_color   <= '0;
      r_pend_valid   <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
      if (w_boundary && r_pend_valid) begin
        r_duty       <= r_pend_color;
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_pend_color <= cmd_color;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign period_start = r_period_start;

  // Channel i takes duty slice i, so red (MSBs) lands on rgb[2].
  for (genvar i = 0; i < 3; i++) begin : g_chan
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_chan (
      .clk      (clk),
      .rst_n    (rst),
      .i_phase  (r_phase),
      .i_duty   (r_duty[i*PWM_BITS +: PWM_BITS]),
      .i_enable (enable),
      .o_pin    (rgb[i])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench: 4-bit PWM, PRESCALE=1 main instance plus a PRESCALE=3 instance.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_color;
  logic        enable;
  logic [2:0]  rgb;
  logic        period_start;

  logic        cmd3_valid;
  logic        cmd3_ready;
  logic [11:0] cmd3_color;
  logic        enable3;
  logic [2:0]  rgb3;
  logic        ps3;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  rgb_seen;
  logic [15:0] pr, pg, pb, pps;
  int          cnt, hi;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PWM_BITS(4), .PRESCALE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_color    (cmd_color),
    .enable       (enable),
    .rgb          (rgb),
    .period_start (period_start)
  );

  rgb_pwm_driver #(.PWM_BITS(4), .PRESCALE(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd3_valid),
    .cmd_ready    (cmd3_ready),
    .cmd_color    (cmd3_color),
    .enable       (enable3),
    .rgb          (rgb3),
    .period_start (ps3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rgb_seen = rgb_seen | rgb;
  endtask

  task automatic wait_ps(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 200);
    check(tag, period_start, 1);
  endtask

  // Sample 16 consecutive cycles; bit j is the value seen for phase j.
  task automatic capture(output logic [15:0] r, output logic [15:0] g,
                         output logic [15:0] b, output logic [15:0] ps);
    for (int j = 0; j < 16; j++) begin
      r[j]  = rgb[2];
      g[j]  = rgb[1];
      b[j]  = rgb[0];
      ps[j] = period_start;
      step();
    end
  endtask

  initial begin
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_color  = '0;
    enable     = 1'b1;
    cmd3_valid = 1'b0;
    cmd3_color = '0;
    enable3    = 1'b1;
    rgb_seen   = '0;

    // Reset state
    step();
    check("rst_rgb", rgb, 3'b000);
    check("rst_ready", cmd_ready, 1);
    check("rst_ps", period_start, 0);
    step();
    rst = 1'b1;

    // Load {15,8,0}
    check("load_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_color = {4'd15, 4'd8, 4'd0};
    step();
    cmd_valid = 1'b0;
    check("load_ready_fall", cmd_ready, 0);
    wait_ps("load_ps", cnt);
    check("load_ps_at", cnt, 15);
    check("load_ready_back", cmd_ready, 1);
    step();
    capture(pr, pg, pb, pps);
    check("load_red", pr, 16'h7FFF);
    check("load_green", pg, 16'h00FF);
    check("load_blue", pb, 16'h0000);
    check("load_ps_pattern", pps, 16'h8000);

    // Back-to-back: second command waits for the first swap
    wait_ps("b2b_align", cnt);
    cmd_valid = 1'b1;
    cmd_color = {4'd4, 4'd0, 4'd0};
    step();
    check("b2b_ready_low", cmd_ready, 0);
    cmd_color = {4'd0, 4'd4, 4'd0};
    cnt = 0;
    while (!cmd_ready && cnt < 100) begin
      step();
      cnt++;
    end
    check("b2b_wait", cnt, 15);
    check("b2b_ps_with_ready", period_start, 1);
    step();
    cmd_valid = 1'b0;
    check("b2b_second_taken", cmd_ready, 0);
    capture(pr, pg, pb, pps);
    check("b2b_red_p1", pr, 16'h000F);
    check("b2b_green_p1", pg, 16'h0000);
    capture(pr, pg, pb, pps);
    check("b2b_red_p2", pr, 16'h0000);
    check("b2b_green_p2", pg, 16'h000F);

    // Accept on the boundary cycle
    wait_ps("bnd_align", cnt);
    repeat (15) step();
    check("bnd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_color = {4'd2, 4'd2, 4'd2};
    step();
    cmd_valid = 1'b0;
    check("bnd_ps", period_start, 1);
    check("bnd_pending", cmd_ready, 0);
    step();
    capture(pr, pg, pb, pps);
    check("bnd_old_red", pr, 16'h0000);
    check("bnd_old_green", pg, 16'h000F);
    check("bnd_old_blue", pb, 16'h0000);
    capture(pr, pg, pb, pps);
    check("bnd_new_red", pr, 16'h0003);
    check("bnd_new_green", pg, 16'h0003);
    check("bnd_new_blue", pb, 16'h0003);
    check("bnd_ready_after", cmd_ready, 1);

    // Enable gating
    cmd_valid = 1'b1;
    cmd_color = {4'd15, 4'd15, 4'd15};
    step();
    cmd_valid = 1'b0;
    wait_ps("en_swap", cnt);
    step();
    check("en_full_on", rgb, 3'b111);
    enable = 1'b0;
    step();
    check("en_gated", rgb, 3'b000);
    check("en_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_color = {4'd1, 4'd1, 4'd1};
    step();
    cmd_valid = 1'b0;
    rgb_seen = '0;
    wait_ps("en_ps1", cnt);
    check("en_ps1_gap", cnt, 13);
    wait_ps("en_ps2", cnt);
    check("en_ps2_gap", cnt, 16);
    check("en_rgb_stayed_off", rgb_seen, 3'b000);
    enable = 1'b1;
    step();
    capture(pr, pg, pb, pps);
    check("en_load_red", pr, 16'h0001);
    check("en_load_green", pg, 16'h0001);
    check("en_load_blue", pb, 16'h0001);

    // Reset mid-operation with duties {8,8,8} and a pending command
    cmd_valid = 1'b1;
    cmd_color = {4'd8, 4'd8, 4'd8};
    step();
    cmd_valid = 1'b0;
    wait_ps("mid_swap", cnt);
    step();
    cmd_valid = 1'b1;
    cmd_color = {4'd1, 4'd2, 4'd3};
    step();
    cmd_valid = 1'b0;
    check("mid_pre_ready", cmd_ready, 0);
    check("mid_pre_rgb", rgb, 3'b111);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rgb", rgb, 3'b000);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_ps", period_start, 0);
    step();
    rst = 1'b1;
    rgb_seen = '0;
    repeat (40) step();
    check("mid_dropped_rgb", rgb_seen, 3'b000);
    check("mid_ready_after", cmd_ready, 1);

    // Prescaler = 3: 48-cycle period, duty 8 is high 24 cycles
    check("ps3_ready", cmd3_ready, 1);
    cmd3_valid = 1'b1;
    cmd3_color = {4'd8, 4'd0, 4'd0};
    step();
    cmd3_valid = 1'b0;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!ps3 && cnt < 400);
    check("ps3_first", ps3, 1);
    cnt = 0;
    hi  = 0;
    do begin
      step();
      cnt++;
      hi += int'(rgb3[2]);
    end while (!ps3 && cnt < 400);
    check("ps3_spacing", cnt, 48);
    check("ps3_red_high", hi, 24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Output end of the RGB sequencer path. It accepts 3-channel colour commands over a valid/ready handshake and renders them on the three LED pins as pulse-width modulation. New duties take effect only at PWM period boundaries, so there are no glitched partial periods. It replaces the direct on/off drive of `rgb` with per-channel brightness.

## Interface

Parameters:
- `PWM_BITS`, 8: duty and phase width; period = 2^PWM_BITS steps.
- `PRESCALE`, 12: clk cycles per PWM step; must be ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. **One clock; reset is asynchronous and active-low.**
- `cmd_valid` in 1: colour command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_color` in 3*PWM_BITS: {red, green, blue} duty, red in the MSBs.
- `enable` in 1: output gate; low forces LEDs off.
- `rgb` out 3: LED drive. `rgb[2]` red, `rgb[1]` green, `rgb[0]` blue. Registered.
- `period_start` out 1: one-cycle pulse when a new PWM period begins. Registered.

## Operation

- **Prescaler**
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` is asserted when the count equals PRESCALE-1. With PRESCALE=1, `tick` is asserted every cycle.
- **Phase counter** (PWM_BITS wide)
  - Increments on `tick` and wraps from 2^PWM_BITS-1 to 0.
  - `boundary` = `tick` && phase == max.
- **State**
  - Active duties `duty_r/g/b`.
  - One-deep pending slot `pend_color` / `pend_valid`.
- **Handshake**
  - `cmd_ready` = !pend_valid (combinational).
  - A transfer occurs on `cmd_valid && cmd_ready`: capture `cmd_color` into `pend_color` and set `pend_valid`.
  - `cmd_color` is ignored when no transfer occurs.
- **Swap**
  - On `boundary` with `pend_valid` set: duties <= `pend_color` and `pend_valid` clears.
  - On `boundary` with no pending command, duties are held.
- **Output**
  - Each cycle, `rgb[i]` <= `enable` && (phase < duty_i).
  - Duty 0 gives a constant low output. Duty max gives high for 2^PWM_BITS-1 of 2^PWM_BITS steps.
  - The comparison is unsigned at PWM_BITS width, with no extension.
- **Enable**
  - `enable` low gates `rgb` only.
  - Prescaler, phase, handshake and swaps continue unaffected.

## Timing

- **Reset values:** prescaler 0, phase 0, duties 0, pend_valid 0, `rgb` 000, `period_start` 0. Therefore `cmd_ready` is 1 during and after reset.
- **Reset mid-operation:** asynchronous assertion clears all state immediately, including a pending command, which is dropped.
- **Swap timing:** a swap on `boundary` in cycle N takes effect as follows.
  - Phase is 0 and duties are new from cycle N+1.
  - `rgb` reflects the new duties from cycle N+2.
  - `period_start` is high in cycle N+1 only.
- **Ready after swap:** `cmd_ready` rises in cycle N+1.
- **Command accepted on a boundary cycle:** the swap uses the pre-transfer `pend_valid` (0), so that command loads at the following boundary.
- **Back-to-back commands:** a second command waits, with `cmd_ready` low, until the first command swaps. There is no overwrite.
- **`enable` timing:** a change in `enable` is seen on `rgb` one cycle later.
- **`period_start` period:** pulses every PRESCALE × 2^PWM_BITS cycles, regardless of commands or `enable`.

## Structure

- **Package `rgb_pkg`:**
  - Default `PWM_BITS` constant.
  - `color_t` packed struct {red, green, blue}.
  - Named colour constants: `COLOR_OFF`, `COLOR_RED`, `COLOR_GREEN`, `COLOR_BLUE`, `COLOR_WHITE` at full duty.
- **Sub-module `pwm_channel`:**
  - Inputs: phase, duty, enable.
  - Output: registered pin.
  - Instantiated 3×.
- Prescaler, phase counter and handshake stay in the top module.

## Test plan

All scenarios use PWM_BITS=4 and PRESCALE=1 (16-cycle period) unless noted.

- **Reset mid-operation:** drive `rst` low while duties are {8,8,8} and a command is pending → immediately `rgb`=000, `cmd_ready`=1, `period_start`=0. After release with no command, `rgb` stays 000 indefinitely.
- **Load {15,8,0}:**
  - Accept → `cmd_ready` falls next cycle.
  - After the next `period_start`, each 16-cycle period shows `rgb[2]` high 15 cycles, `rgb[1]` high 8 cycles (phases 0–7), `rgb[0]` never high.
  - `cmd_ready` returns to 1 in the `period_start` cycle.
- **Back-to-back:** offer {4,0,0} then hold {0,4,0} with `cmd_valid`=1 → second transfer occurs only after the first swap. Red shows 4/16 for exactly one period, then green 4/16.
- **Accept on boundary:** transfer {2,2,2} in the phase==15 cycle → no change at that boundary; new duty visible after the boundary 16 cycles later.
- **Enable gating:** duties {15,15,15}, drop `enable` → `rgb`=000 from the next cycle. `period_start` keeps pulsing every 16 cycles, and a command sent meanwhile still loads.
- **Prescaler:** PRESCALE=3 → `period_start` spacing is 48 cycles; duty 8 gives 24 high cycles per period.
